adder_pipe_n_bit: RTL and testbench
===================================

// Module: adder_pipe_n_bit
// PURPOSE
//  Parametrised, pipelined ripple-chunk adder/subtractor with valid/ready handshake; next-gen of the 8-bit adder.
//  Splits WIDTH into STAGES equal chunks; one chunk resolved per cycle, carry registered between stages.
//  Adds subtract mode, signed-overflow flag and backpressure; feeds the regression datapath sum/error terms.
// PARAMETERS
//  WIDTH   16  operand/result width in bits; must be divisible by STAGES
//  STAGES  2   pipeline depth = latency in cycles; 1..WIDTH; chunk width CW = WIDTH/STAGES
// PORTS
//  clk        in   1      rising-edge clock; single clock domain
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand beat offered
//  in_ready   out  1      block can accept operand beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: add, 1: subtract
//  out_valid  out  1      result beat available
//  out_ready  in   1      downstream accepts result beat
//  sum        out  WIDTH  result
//  cy         out  1      carry-out (add) / NOT borrow-out (sub)
//  ovf        out  1      two's-complement signed overflow
// BEHAVIOUR
//  Reset (async, rst_n=0): all stage valid bits, out_valid, sum, cy and ovf -> 0; in-flight beats discarded.
//   Release is not a transfer; first accept no earlier than first clk edge with rst_n=1.
//  Arithmetic, modulo 2^WIDTH:
//   sub=0: {cy,sum} = a + b + cin
//   sub=1: {cy,sum} = a + ~b + !cin  (= a - b - cin; cy=1 means no borrow)
//   ovf = (a[W-1] == be[W-1]) && (sum[W-1] != a[W-1]), be = sub ? ~b : b.
//  Handshake:
//   Input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
//   Payload and out_valid hold stable while out_valid && !out_ready.
//   in_ready is combinational from stall state, never from in_valid.
//  Pipeline: stage k (0..STAGES-1) adds chunk k of a/be plus carry from stage k-1.
//   Stage 0 carry-in = sub ? !cin : cin.
//   Upper chunks are delayed in skew registers; completed lower sum chunks are carried forward.
//   Stage k loads when its valid bit is 0 or stage k+1 loads.
//   Last stage loads when !out_valid || out_ready; in_ready = stage-0 load enable.
//  Latency: exactly STAGES cycles from accept edge to out_valid=1 with no stall.
//  Throughput: one beat/cycle while out_ready=1, including simultaneous accept and consume in one cycle.
//  Bubbles collapse: a stalled output still lets earlier empty stages fill; all STAGES slots usable.
//  Full: all stages valid and out_ready=0 -> in_ready=0; beats never dropped, duplicated or reordered.
//  Empty: out_valid=0; sum/cy/ovf hold last value (not required to be 0).
//  Wrap-around: 0xFF..F + 1 -> sum=0, cy=1, no error.
//  STAGES=1: purely registered adder, in_ready = !out_valid || out_ready.
//  in_valid/a/b/cin/sub are ignored when not accepted; X on them while in_valid=0 must not propagate.
// STRUCTURE
//  Shared header adder_defs.vh (team package): ADD/SUB mode encodings, chunk-width macro, WIDTH%STAGES check.
//  Sub-module adder_chunk #(CW): combinational {co,s} = x + y + ci, instantiated STAGES times via generate.
//  Top holds skew/valid registers and handshake logic; elaboration error if WIDTH % STAGES != 0.
// TESTING (bench: WIDTH=8 STAGES=2 unless noted; scoreboard vs behavioural a+b+cin / a-b-cin)
//  1+1, cin=0, sub=0 -> sum=2, cy=0, ovf=0, out_valid exactly 2 cycles after accept.
//  255+1, cin=1 -> sum=1, cy=1; 0xAA+0x55 c0 -> 0xFF cy0; 0xB5+0xC9 c1 -> 0x7F cy1 ovf1.
//  sub: 5-3 c0 -> 2 cy1; 3-5 c0 -> 0xFE cy0; 0x80-0x01 -> 0x7F ovf1.
//  Backpressure: stream 10 beats, out_ready=0 for 4 cycles -> in_ready=0 after 2 held beats; all 10 in order.
//  Throughput: out_ready=1, 100 random beats back-to-back -> 100 results in 101 cycles (STAGES=2).
//  Reset mid-flight: assert rst_n=0 with 2 beats in pipe -> out_valid=0 at once, no stale beat after release;
//   repeat with WIDTH=16 STAGES=4 and WIDTH=8 STAGES=1.

Source files
------------

// File: rtl/adder_pipe_n_bit_pkg.sv
// ---------------------------------------------------------------------------
// adder_pipe_n_bit_pkg
//   Shared definitions for the pipelined chunked adder/subtractor:
//   mode encoding and the helpers that turn WIDTH/STAGES into a chunk width
//   and validate the split at elaboration time.
// ---------------------------------------------------------------------------
package adder_pipe_n_bit_pkg;

    // Operation selected by the 'sub' input.
    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    // Bits resolved by each pipeline stage.
    function automatic int chunk_width(int width, int stages);
        return (stages > 0) ? width / stages : width;
    endfunction

    // A split is legal when every stage gets the same non-zero chunk.
    function automatic bit split_ok(int width, int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// ---------------------------------------------------------------------------
// adder_chunk
//   Combinational CW-bit slice adder: {co, s} = x + y + ci.
//   Ports:
//     x, y  in   CW  chunk operands
//     ci    in   1   carry into the chunk
//     s     out  CW  chunk sum
//     co    out  1   carry out of the chunk
// ---------------------------------------------------------------------------
module adder_chunk
    import adder_pipe_n_bit_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co
);

    assign {co, s} = {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, ci};

endmodule

// File: rtl/adder_pipe_n_bit.sv
// ---------------------------------------------------------------------------
// adder_pipe_n_bit
//   Pipelined adder/subtractor that resolves WIDTH/STAGES bits per cycle,
//   registering the carry between stages, with a valid/ready handshake on
//   both sides and bubble-collapsing backpressure.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     in_valid/in_ready   operand beat handshake (in_ready never looks at in_valid)
//     a, b, cin, sub      operands, carry/borrow-in, 0 = add / 1 = subtract
//     out_valid/out_ready result beat handshake
//     sum, cy, ovf        result, carry-out (NOT borrow when subtracting),
//                         two's-complement overflow
// ---------------------------------------------------------------------------
module adder_pipe_n_bit
    import adder_pipe_n_bit_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cy,
    output logic             ovf
);

    localparam int CW = chunk_width(WIDTH, STAGES);

    generate
        if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
            $error("adder_pipe_n_bit: WIDTH must be a multiple of STAGES, STAGES in 1..WIDTH");
        end
    endgenerate

    // One pipeline slot: full operands travel along (upper chunks still
    // pending, top bits needed for overflow), lower sum chunks accumulate.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] be;
        logic [WIDTH-1:0] s;
        logic             c;
    } stage_t;

    stage_t            head;
    stage_t            nxt   [STAGES];
    stage_t            stg_q [STAGES];
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] load;
    mode_e             mode;

    assign mode = mode_e'(sub);

    // Subtraction is a + ~b + !cin, so both the B operand and the stage-0
    // carry are inverted up front.
    always_comb begin
        // NOTE: every field gets a value before any conditional update, so no latch is inferred.
        head    = '0;
        head.a  = a;
        head.be = (mode == MODE_SUB) ? ~b : b;
        head.c  = (mode == MODE_SUB) ? ~cin : cin;
    end

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            stage_t           src_k;
            logic [CW-1:0]    chunk_s;
            logic             chunk_co;
            logic [WIDTH-1:0] merged;

            if (k == 0) begin : g_head
                assign src_k    = head;
                assign src_v[k] = in_valid;
            end else begin : g_link
                assign src_k    = stg_q[k-1];
                assign src_v[k] = vld_q[k-1];
            end

            adder_chunk #(.CW(CW)) u_chunk (
                .x  (src_k.a[k*CW +: CW]),
                .y  (src_k.be[k*CW +: CW]),
                .ci (src_k.c),
                .s  (chunk_s),
                .co (chunk_co)
            );

            always_comb begin
                merged                = src_k.s;
                merged[k*CW +: CW]    = chunk_s;
            end

            assign nxt[k] = '{a: src_k.a, be: src_k.be, s: merged, c: chunk_co};

            // Stage k may advance when it, or any slot downstream of it, is
            // empty, or when the output is being drained. This is the
            // unrolled form of "empty, or the next stage loads".
            assign load[k] = out_ready || !(&vld_q[STAGES-1:k]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            // NOTE: the datapath slots are reset as well, since sum/cy/ovf are observable and must read 0 after reset.
            for (int k = 0; k < STAGES; k++) begin
                stg_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    // NOTE: non-blocking assignment so every stage samples its predecessor's pre-edge value.
                    vld_q[k] <= src_v[k];
                    // Payload only moves with a valid beat: an emptied output
                    // keeps its last result and idle X inputs never enter.
                    if (src_v[k]) begin
                        stg_q[k] <= nxt[k];
                    end
                end
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = vld_q[STAGES-1];
    assign sum       = stg_q[STAGES-1].s;
    assign cy        = stg_q[STAGES-1].c;
    // Overflow: operands share a sign and the result sign differs from it.
    assign ovf       = (stg_q[STAGES-1].a[WIDTH-1] == stg_q[STAGES-1].be[WIDTH-1]) &&
                       (stg_q[STAGES-1].s[WIDTH-1] != stg_q[STAGES-1].a[WIDTH-1]);

endmodule

// File: tb/tb_adder_pipe_n_bit.sv
// ---------------------------------------------------------------------------
// tb_adder_pipe_n_bit
//   Main instance WIDTH=8 STAGES=2 with a scoreboard fed by an arithmetic
//   reference model; two further instances (16/4 and 8/1) share a small
//   stimulus set for reset-mid-flight and latency checks.
// ---------------------------------------------------------------------------
module tb_adder_pipe_n_bit;

    localparam int S0 = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance (8/2)
    logic       v0 = 1'b0, or0 = 1'b0, c0 = 1'b0, s0 = 1'b0;
    logic [7:0] a0 = '0, b0 = '0;
    logic       ir0, ov0, cy0, ovf0;
    logic [7:0] sum0;

    // Auxiliary instances (16/4 and 8/1) share their stimulus
    logic        av = 1'b0, aor = 1'b0, ac = 1'b0, as = 1'b0;
    logic [15:0] aa = '0, ab = '0;
    logic        ir1, ov1, cy1, ovf1, ir2, ov2, cy2, ovf2;
    logic [15:0] sum1;
    logic [7:0]  sum2;

    adder_pipe_n_bit #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(ir0), .a(a0), .b(b0),
        .cin(c0), .sub(s0), .out_valid(ov0), .out_ready(or0), .sum(sum0), .cy(cy0), .ovf(ovf0)
    );

    adder_pipe_n_bit #(.WIDTH(16), .STAGES(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(av), .in_ready(ir1), .a(aa), .b(ab),
        .cin(ac), .sub(as), .out_valid(ov1), .out_ready(aor), .sum(sum1), .cy(cy1), .ovf(ovf1)
    );

    adder_pipe_n_bit #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(av), .in_ready(ir2), .a(aa[7:0]), .b(ab[7:0]),
        .cin(ac), .sub(as), .out_valid(ov2), .out_ready(aor), .sum(sum2), .cy(cy2), .ovf(ovf2)
    );

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   outs = 0;
    int   last_out_cyc = -1;
    int   acc_cyc = 0;
    res_t sb[$];

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic res_t model(int w, logic [15:0] a, logic [15:0] b, logic cin, logic sub);
        res_t   r;
        longint m, ua, ub, t, sa, sb2, sr;
        m   = longint'(1) << w;
        ua  = longint'(a) & (m - 1);
        ub  = longint'(b) & (m - 1);
        t   = sub ? ua - ub - longint'(cin) : ua + ub + longint'(cin);
        r.s = 16'(((t % m) + m) % m);
        r.c = sub ? (t >= 0) : (t >= m);
        sa  = (ua >= m / 2) ? ua - m : ua;
        sb2 = (ub >= m / 2) ? ub - m : ub;
        sr  = sub ? sa - sb2 - longint'(cin) : sa + sb2 + longint'(cin);
        r.o = (sr < -(m / 2)) || (sr >= m / 2);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard for the main instance: compare on consume, record on accept.
    always @(negedge clk) begin
        res_t e;
        if (rst_n) begin
            if (ov0 && or0) begin
                if (sb.size() == 0) begin
                    check("spurious_out", ov0, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("sb_sum", sum0, e.s);
                    check("sb_cy", cy0, e.c);
                    check("sb_ovf", ovf0, e.o);
                    outs++;
                    last_out_cyc = cyc;
                end
            end
            if (v0 && ir0) sb.push_back(model(8, {8'h00, a0}, {8'h00, b0}, c0, s0));
        end
    end

    // Called at posedge+#1; returns at posedge+#1 after the accepting edge,
    // with the beat still offered so back-to-back calls stream.
    task automatic send0(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
        bit ok;
        ok = 0;
        a0 = a; b0 = b; c0 = c; s0 = s; v0 = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (ir0) begin
                ok      = 1;
                acc_cyc = cyc;
            end
            @(posedge clk); #1;
        end
        if (!ok) check("send_timeout", ir0, 1'b1);
    endtask

    task automatic idle0();
        v0 = 1'b0; a0 = 'x; b0 = 'x; c0 = 'x; s0 = 'x;
    endtask

    task automatic wait_out0();
        bit ok;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (ov0) ok = 1;
        end
        if (!ok) check("out_timeout", ov0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        typedef struct {
            logic [7:0] a, b;
            logic       c, s;
            logic [7:0] es;
            logic       ecy, eovf;
        } vec_t;
        vec_t       vt[7];
        logic [7:0] ba[10], bb[10];
        logic       bc[10], bs[10];
        res_t       e16, e8, r0;
        int         base, first;

        vt[0] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
        vt[1] = '{8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        vt[2] = '{8'hB5, 8'hC9, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
        vt[3] = '{8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};
        vt[4] = '{8'h03, 8'h05, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vt[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vt[6] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};

        // Reset state
        #3;
        check("rst_out_valid", ov0, 1'b0);
        check("rst_sum", sum0, 8'h00);
        check("rst_cy", cy0, 1'b0);
        check("rst_ovf", ovf0, 1'b0);
        check("rst_valid16", ov1, 1'b0);
        check("rst_valid1", ov2, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1 + 1 with latency: out_valid exactly S0 cycles after the accept cycle
        or0 = 1'b1;
        send0(8'd1, 8'd1, 1'b0, 1'b0);
        idle0();
        @(negedge clk);
        check("lat_early", ov0, 1'b0);
        @(negedge clk);
        check("lat_cycles", cyc - acc_cyc, S0);
        check("lat_valid", ov0, 1'b1);
        check("one_plus_one", sum0, 8'd2);
        check("one_plus_one_cy", cy0, 1'b0);
        check("one_plus_one_ovf", ovf0, 1'b0);
        @(posedge clk); #1;

        // Directed arithmetic corner cases
        for (int i = 0; i < 7; i++) begin
            send0(vt[i].a, vt[i].b, vt[i].c, vt[i].s);
            idle0();
            wait_out0();
            check($sformatf("vec%0d_sum", i), sum0, vt[i].es);
            check($sformatf("vec%0d_cy", i), cy0, vt[i].ecy);
            check($sformatf("vec%0d_ovf", i), ovf0, vt[i].eovf);
            @(posedge clk); #1;
        end

        // Backpressure: two beats fill the pipe, output held for 4 cycles
        for (int i = 0; i < 10; i++) begin
            ba[i] = 8'($urandom); bb[i] = 8'($urandom);
            bc[i] = 1'($urandom); bs[i] = 1'($urandom);
        end
        r0   = model(8, {8'h00, ba[0]}, {8'h00, bb[0]}, bc[0], bs[0]);
        base = outs;
        or0  = 1'b0;
        send0(ba[0], bb[0], bc[0], bs[0]);
        send0(ba[1], bb[1], bc[1], bs[1]);
        a0 = ba[2]; b0 = bb[2]; c0 = bc[2]; s0 = bs[2];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_in_ready", ir0, 1'b0);
            check("bp_out_valid", ov0, 1'b1);
            check("bp_hold_sum", sum0, r0.s[7:0]);
            check("bp_hold_cy", cy0, r0.c);
        end
        @(posedge clk); #1;
        or0 = 1'b1;
        for (int i = 2; i < 10; i++) send0(ba[i], bb[i], bc[i], bs[i]);
        idle0();
        repeat (S0 + 3) @(negedge clk);
        check("bp_all_out", outs - base, 10);
        check("bp_drained", sb.size(), 0);
        @(posedge clk); #1;

        // Throughput: 100 random back-to-back beats with out_ready held high
        base  = outs;
        first = 0;
        for (int i = 0; i < 100; i++) begin
            a0 = 8'($urandom); b0 = 8'($urandom); c0 = 1'($urandom); s0 = 1'($urandom);
            v0 = 1'b1;
            @(negedge clk);
            if (i == 0) first = cyc;
            if (!ir0) check("tp_in_ready", ir0, 1'b1);
            @(posedge clk); #1;
        end
        idle0();
        repeat (S0 + 2) @(negedge clk);
        check("tp_count", outs - base, 100);
        check("tp_span", last_out_cyc - first, 100 + S0 - 1);
        @(posedge clk); #1;

        // Reset mid-flight on all three instances
        or0 = 1'b0; aor = 1'b0;
        av = 1'b1; aa = 16'($urandom); ab = 16'($urandom); ac = 1'b0; as = 1'b0;
        send0(8'($urandom), 8'($urandom), 1'b0, 1'b0);
        send0(8'($urandom), 8'($urandom), 1'b1, 1'b1);
        idle0();
        av = 1'b0;
        check("mid_pre_valid", ov0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", ov0, 1'b0);
        check("mid_rst_valid16", ov1, 1'b0);
        check("mid_rst_valid1", ov2, 1'b0);
        check("mid_rst_sum", sum0, 8'h00);
        sb.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        or0 = 1'b1; aor = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_valid", ov0, 1'b0);
            check("post_rst_valid16", ov1, 1'b0);
            check("post_rst_valid1", ov2, 1'b0);
        end
        @(posedge clk); #1;

        // One beat into both auxiliary instances: latency 1 and 4
        aa = 16'($urandom); ab = 16'($urandom); ac = 1'($urandom); as = 1'($urandom);
        e16 = model(16, aa, ab, ac, as);
        e8  = model(8, {8'h00, aa[7:0]}, {8'h00, ab[7:0]}, ac, as);
        av  = 1'b1;
        @(negedge clk);
        check("aux_ready16", ir1, 1'b1);
        check("aux_ready1", ir2, 1'b1);
        @(posedge clk); #1 av = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("s1_valid_c%0d", k), ov2, 1'(k == 1));
            check($sformatf("s4_valid_c%0d", k), ov1, 1'(k == 4));
            if (k == 1) begin
                check("s1_sum", sum2, e8.s[7:0]);
                check("s1_cy", cy2, e8.c);
                check("s1_ovf", ovf2, e8.o);
            end
            if (k == 4) begin
                check("s4_sum", sum1, e16.s);
                check("s4_cy", cy1, e16.c);
                check("s4_ovf", ovf1, e16.o);
            end
        end

        // STAGES=1: in_ready = !out_valid || out_ready
        @(posedge clk); #1;
        aor = 1'b0; av = 1'b1;
        @(negedge clk);
        check("s1_ready_empty", ir2, 1'b1);
        @(posedge clk); #1 av = 1'b0;
        @(negedge clk);
        check("s1_ready_full", ir2, 1'b0);
        check("s1_full_valid", ov2, 1'b1);
        @(posedge clk); #1 aor = 1'b1;
        @(negedge clk);
        check("s1_ready_drain", ir2, 1'b1);
        @(posedge clk); #1;

        // Main instance still works after the reset
        send0(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        idle0();
        repeat (S0 + 2) @(negedge clk);
        check("final_drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
